// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse receiver: synchronizes the raw PS/2 lines, decodes 11-bit
// device-to-host frames, assembles 3-byte movement packets and accumulates
// saturating 8-bit cursor positions whose upper nibbles drive the game.
module ps2_mouse_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 25000,
    parameter int unsigned DELTA_SHIFT    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [3:0] mouse_x,
    output logic [3:0] mouse_y,
    output logic       btn_left,
    output logic       btn_right,
    output logic       packet_valid,
    output logic       frame_error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t             state, state_next;
    logic [2:0]         clk_sync;
    logic [1:0]         data_sync;
    logic               fall;
    logic               bit_in;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift_reg;
    logic               parity_ok;
    logic               byte_ok;
    logic               stop_err;
    logic [1:0]         idx;
    logic               st_left, st_right, st_xs, st_ys, st_xo, st_yo;
    logic [7:0]         dx_byte;
    logic [7:0]         pos_x, pos_y;
    logic [7:0]         pos_x_new, pos_y_new;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               active;
    logic               timeout_hit;
    logic signed [8:0]  dx9, dy9;
    logic [9:0]         sum_x, sum_y;

    // Clamp a 10-bit two's complement sum into the range [0, 255].
    function automatic logic [7:0] clamp8(input logic [9:0] s);
        if (s[9])
            return 8'h00;
        else if (s[8])
            return 8'hFF;
        else
            return s[7:0];
    endfunction

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign bit_in = data_sync[1];
    assign active = (state != S_IDLE) || (idx != 2'd0);
    // A falling edge in the same cycle as expiry wins: no timeout is raised.
    assign timeout_hit = active && !fall && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Two-flop synchronizers plus one extra clock stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    // Inactivity counter: cleared by every PS/2 edge, runs only mid-frame/packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (fall || !active || timeout_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Frame FSM next-state logic, advanced by PS/2 falling edges.
    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = S_IDLE;
        end else if (fall) begin
            case (state)
                S_IDLE:   if (!bit_in) state_next = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
                S_PARITY: state_next = S_STOP;
                S_STOP:   state_next = S_IDLE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // Frame FSM outputs: byte accepted or frame rejected at the stop bit.
    always_comb begin
        byte_ok  = 1'b0;
        stop_err = 1'b0;
        if (fall && state == S_STOP) begin
            byte_ok  = parity_ok && bit_in;
            stop_err = !(parity_ok && bit_in);
        end
    end

    // Serial shift register, bit counter and odd-parity check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            parity_ok <= 1'b0;
        end else if (fall) begin
            case (state)
                S_IDLE: bit_cnt <= '0;
                S_DATA: begin
                    shift_reg <= {bit_in, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                S_PARITY: parity_ok <= ^{shift_reg, bit_in};
                default: ;
            endcase
        end
    end

    // Position arithmetic for the packet completed by the byte now in shift_reg.
    always_comb begin
        dx9       = st_xo ? 9'sd0 : $signed({st_xs, dx_byte});
        dy9       = st_yo ? 9'sd0 : $signed({st_ys, shift_reg});
        dx9       = dx9 >>> DELTA_SHIFT;
        dy9       = dy9 >>> DELTA_SHIFT;
        sum_x     = {2'b00, pos_x} + {dx9[8], dx9};
        sum_y     = {2'b00, pos_y} - {dy9[8], dy9};
        pos_x_new = clamp8(sum_x);
        pos_y_new = clamp8(sum_y);
    end

    // Packet assembly, position/button update and the one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            st_left      <= 1'b0;
            st_right     <= 1'b0;
            st_xs        <= 1'b0;
            st_ys        <= 1'b0;
            st_xo        <= 1'b0;
            st_yo        <= 1'b0;
            dx_byte      <= '0;
            pos_x        <= 8'h80;
            pos_y        <= 8'h80;
            btn_left     <= 1'b0;
            btn_right    <= 1'b0;
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            frame_error  <= stop_err | timeout_hit;
            if (stop_err || timeout_hit) begin
                idx <= '0;
            end else if (byte_ok) begin
                case (idx)
                    2'd0: begin
                        if (shift_reg[3]) begin
                            st_left  <= shift_reg[0];
                            st_right <= shift_reg[1];
                            st_xs    <= shift_reg[4];
                            st_ys    <= shift_reg[5];
                            st_xo    <= shift_reg[6];
                            st_yo    <= shift_reg[7];
                            idx      <= 2'd1;
                        end
                    end
                    2'd1: begin
                        dx_byte <= shift_reg;
                        idx     <= 2'd2;
                    end
                    2'd2: begin
                        pos_x        <= pos_x_new;
                        pos_y        <= pos_y_new;
                        btn_left     <= st_left;
                        btn_right    <= st_right;
                        packet_valid <= 1'b1;
                        idx          <= 2'd0;
                    end
                    default: idx <= '0;
                endcase
            end
        end
    end

    assign mouse_x = pos_x[7:4];
    assign mouse_y = pos_y[7:4];

endmodule
